// File: rtl/uart_rx_packet_parser.sv
// Frames the UART receiver byte stream into SOF/LEN/payload/CHK packets and
// releases checksum-verified payloads on a valid/ready stream.
// Optional inter-byte timeout built when PARSER_TIMEOUT_EN is defined.
module uart_rx_packet_parser #(
  parameter logic [7:0]  SOF           = 8'hA5,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_ticks,
  input  logic [7:0] rx_dout,
  input  logic       s_ticks,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic [7:0] pkt_len,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_overrun,
  output logic       err_timeout
);

  localparam int unsigned IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

  typedef enum logic [2:0] {StHunt, StLen, StPayload, StChk, StOut} state_e;

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d, rd_next;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic [7:0]      pkt_len_q, pkt_len_d;
  logic            err_len_q, err_len_d;
  logic            err_chk_q, err_chk_d;
  logic            err_overrun_q, err_overrun_d;
  logic            wr_en;
  logic            timeout_hit;
  logic [7:0]      mem_q [MAX_LEN];

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    chk_d         = chk_q;
    idx_d         = idx_q;
    rd_idx_d      = rd_idx_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    pkt_len_d     = pkt_len_q;
    err_len_d     = 1'b0;
    err_chk_d     = 1'b0;
    err_overrun_d = 1'b0;
    wr_en         = 1'b0;
    rd_next       = rd_idx_q + 1'b1;
    unique case (state_q)
      StHunt: begin
        if (rx_done_ticks && (rx_dout == SOF)) state_d = StLen;
      end
      StLen: begin
        if (rx_done_ticks) begin
          if ((rx_dout == 8'd0) || (rx_dout > MaxLenB)) begin
            err_len_d = 1'b1;
            state_d   = StHunt;
          end else begin
            len_d   = rx_dout;
            chk_d   = rx_dout;
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (rx_done_ticks) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ rx_dout;
          // Hold idx on the final byte so a MAX_LEN payload never wraps it.
          if (8'(idx_q) == (len_q - 8'd1)) state_d = StChk;
          else                              idx_d   = idx_q + 1'b1;
        end
      end
      StChk: begin
        if (rx_done_ticks) begin
          if (rx_dout == chk_q) begin
            rd_idx_d  = '0;
            m_valid_d = 1'b1;
            m_data_d  = mem_q[0];
            m_last_d  = (len_q == 8'd1);
            pkt_len_d = len_q;
            state_d   = StOut;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end
      StOut: begin
        err_overrun_d = rx_done_ticks;
        if (m_ready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = StHunt;
          end else begin
            rd_idx_d = rd_next;
            m_data_d = mem_q[rd_next];
            m_last_d = (8'(rd_next) == (len_q - 8'd1));
          end
        end
      end
      default: state_d = StHunt;
    endcase
    if (timeout_hit) state_d = StHunt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StHunt;
      len_q         <= 8'd0;
      chk_q         <= 8'd0;
      idx_q         <= '0;
      rd_idx_q      <= '0;
      m_data_q      <= 8'd0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      pkt_len_q     <= 8'd0;
      err_len_q     <= 1'b0;
      err_chk_q     <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      chk_q         <= chk_d;
      idx_q         <= idx_d;
      rd_idx_q      <= rd_idx_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      pkt_len_q     <= pkt_len_d;
      err_len_q     <= err_len_d;
      err_chk_q     <= err_chk_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Payload buffer is intentionally left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx_q] <= rx_dout;
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int unsigned     TickW    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(TIMEOUT_TICKS - 1);

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             timing_active;
  logic             err_timeout_q;

  assign timing_active = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  // A byte arriving on the expiring tick wins over the timeout.
  assign timeout_hit   = timing_active && s_ticks && !rx_done_ticks && (tick_cnt_q == TickLast);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!timing_active || rx_done_ticks || (state_d != state_q)) tick_cnt_d = '0;
    else if (s_ticks)                                             tick_cnt_d = tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      err_timeout_q <= timeout_hit;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg  = s_ticks | (TIMEOUT_TICKS == 0);
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign pkt_len     = pkt_len_q;
  assign err_len     = err_len_q;
  assign err_chk     = err_chk_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Directed bench for uart_rx_packet_parser: packet-level queue model checked every
// cycle, plus literal expectations. Timeout section runs only with PARSER_TIMEOUT_EN.
module tb_uart_rx_packet_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_ticks;
  logic [7:0] rx_dout;
  logic       s_ticks;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [7:0] pkt_len;
  logic       err_len, err_chk, err_overrun, err_timeout;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  uart_rx_packet_parser #(
    .SOF          (8'hA5),
    .MAX_LEN      (16),
    .TIMEOUT_TICKS(320)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_ticks(rx_done_ticks),
    .rx_dout      (rx_dout),
    .s_ticks      (s_ticks),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .pkt_len      (pkt_len),
    .err_len      (err_len),
    .err_chk      (err_chk),
    .err_overrun  (err_overrun),
    .err_timeout  (err_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Packet-level model: collect the frame after SOF, verify it whole, queue the payload.
  logic [7:0] frame[$];
  logic [7:0] outq[$];
  logic [7:0] exp_pkt = 8'd0;
  bit         collecting = 1'b0;
  bit         e_len = 1'b0, e_chk = 1'b0, e_ovr = 1'b0, e_to = 1'b0;
  int         ticks = 0;

  always @(posedge clk) begin
    logic [7:0] x;
    e_len = 1'b0;
    e_chk = 1'b0;
    e_ovr = 1'b0;
    e_to  = 1'b0;
    if (reset) begin
      collecting = 1'b0;
      frame.delete();
      outq.delete();
      exp_pkt = 8'd0;
      ticks   = 0;
    end else if (outq.size() != 0) begin
      if (rx_done_ticks) e_ovr = 1'b1;
      if (m_ready) void'(outq.pop_front());
    end else begin
`ifdef PARSER_TIMEOUT_EN
      if (collecting && !rx_done_ticks && s_ticks) begin
        ticks++;
        if (ticks == 320) begin
          e_to = 1'b1;
          collecting = 1'b0;
        end
      end
`endif
      if (rx_done_ticks) begin
        ticks = 0;
        if (!collecting) begin
          if (rx_dout == 8'hA5) begin
            collecting = 1'b1;
            frame.delete();
          end
        end else begin
          frame.push_back(rx_dout);
          if (frame.size() == 1 && (rx_dout == 8'd0 || rx_dout > 8'd16)) begin
            e_len = 1'b1;
            collecting = 1'b0;
          end else if (frame.size() == int'(frame[0]) + 2) begin
            x = 8'd0;
            for (int i = 0; i < frame.size() - 1; i++) x ^= frame[i];
            if (x == frame[frame.size()-1]) begin
              for (int i = 1; i < frame.size() - 1; i++) outq.push_back(frame[i]);
              exp_pkt = frame[0];
            end else begin
              e_chk = 1'b1;
            end
            collecting = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_valid", m_valid, outq.size() != 0);
      check("err_len", err_len, e_len);
      check("err_chk", err_chk, e_chk);
      check("err_overrun", err_overrun, e_ovr);
      check("err_timeout", err_timeout, e_to);
      if (outq.size() != 0) begin
        check("m_data", m_data, outq[0]);
        check("m_last", m_last, outq.size() == 1);
        check("pkt_len", pkt_len, exp_pkt);
      end
    end
  end

  // Called right after a falling edge; byte is sampled on the next rising edge.
  task automatic send(input logic [7:0] b);
    rx_done_ticks = 1'b1;
    rx_dout       = b;
    @(negedge clk);
    rx_done_ticks = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    rx_done_ticks = 1'b0;
    rx_dout       = 8'd0;
    s_ticks       = 1'b0;
    m_ready       = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    check("rst m_valid", m_valid, 0);
    check("rst m_last", m_last, 0);
    check("rst m_data", m_data, 0);
    check("rst pkt_len", pkt_len, 0);
    check("rst errs", {err_len, err_chk, err_overrun, err_timeout}, 0);
    reset = 1'b0;

    // Good packet, literal stream 01 02 03.
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h03);
    check("good d0", {m_valid, m_last, m_data}, {2'b10, 8'h01});
    check("good len", pkt_len, 8'd3);
    @(negedge clk);
    check("good d1", {m_valid, m_last, m_data}, {2'b10, 8'h02});
    @(negedge clk);
    check("good d2", {m_valid, m_last, m_data}, {2'b11, 8'h03});
    @(negedge clk);
    check("good done", m_valid, 0);
    idle(2);

    // Bad checksum, then a one-byte packet.
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    check("bad chk pulse", {err_chk, m_valid}, 2'b10);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    check("one byte", {m_valid, m_last, m_data}, {2'b11, 8'h7E});
    idle(2);

    // Length errors, junk, then a valid packet.
    send(8'hA5); send(8'h00);
    check("len zero", err_len, 1);
    send(8'hA5); send(8'h11);
    check("len 17", err_len, 1);
    send(8'h00); send(8'hFF); send(8'h12);
    send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'hFD);
    check("after junk", {m_valid, m_data}, {1'b1, 8'hAA});
    idle(3);

    // Backpressure with an overrun byte mid-stall.
    m_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h03);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        rx_done_ticks = 1'b1;
        rx_dout       = 8'h5A;
      end
      @(negedge clk);
      rx_done_ticks = 1'b0;
      check("stall hold", {m_valid, m_last, m_data}, {2'b10, 8'h01});
      if (i == 10) check("stall overrun", err_overrun, 1);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("resume d1", m_data, 8'h02);
    @(negedge clk);
    check("resume d2", {m_last, m_data}, {1'b1, 8'h03});
    idle(2);

    // Reset mid-packet.
    send(8'hA5); send(8'h04); send(8'h01);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst outs", {m_valid, m_last, err_len, err_chk, err_overrun}, 0);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h54);
    check("post rst", {m_valid, m_data}, {1'b1, 8'h55});
    idle(2);

    // SOF inside payload, then byte on the final handshake (overrun), then immediate SOF.
    send(8'hA5); send(8'h02); send(8'hA5); send(8'h01); send(8'hA6);
    idle(3);
    send(8'hA5); send(8'h01); send(8'h33); send(8'h32);
    send(8'h44);
    check("last hs overrun", err_overrun, 1);
    send(8'hA5); send(8'h01); send(8'h66); send(8'h67);
    check("back to back", {m_valid, m_data}, {1'b1, 8'h66});
    idle(2);

    // MAX_LEN payload with intermittent ready.
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h10);
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 3) != 0;
      @(negedge clk);
    end
    m_ready = 1'b1;
    idle(3);

`ifdef PARSER_TIMEOUT_EN
    send(8'hA5); send(8'h02); send(8'h11);
    for (int i = 0; i < 320; i++) begin
      s_ticks = 1'b1;
      @(negedge clk);
      check("timeout edge", err_timeout, i == 319);
    end
    s_ticks = 1'b0;
    send(8'hA5); send(8'h02); send(8'h11);
    s_ticks = 1'b1;
    idle(319);
    s_ticks = 1'b0;
    send(8'h22);
    check("no timeout", err_timeout, 0);
    send(8'h31);
    check("late pkt", {m_valid, m_data}, {1'b1, 8'h11});
    idle(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
